// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared width codes, FSM state type and defaults for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DMEM_BYTES_DEFAULT = 2048;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic: load extraction with sign/zero
//               extension and sub-word merge for read-modify-write stores.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes (little-endian)
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane into a full load result
    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Build the word to write back: old word with the store lane replaced
    always_comb begin
        o_merge_word = i_word;
        if (i_funct3[1:0] == 2'b00) begin
            case (i_offset)
                2'd0:    o_merge_word[7:0]   = i_wdata[7:0];
                2'd1:    o_merge_word[15:8]  = i_wdata[7:0];
                2'd2:    o_merge_word[23:16] = i_wdata[7:0];
                default: o_merge_word[31:24] = i_wdata[7:0];
            endcase
        end else begin
            if (i_offset[1]) begin
                o_merge_word[31:16] = i_wdata[15:0];
            end else begin
                o_merge_word[15:0]  = i_wdata[15:0];
            end
        end
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Memory-stage load/store unit. Formats loads, performs SB/SH
//               as a two-cycle read-modify-write, flags access errors.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int          DMEM_BYTES     = DMEM_BYTES_DEFAULT,
    parameter logic [31:0] RESET_VEC_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_dmem_limit = 32'(DMEM_BYTES);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_merge;
    logic [31:0] r_addr;

    logic [31:0] w_aligned;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;
    logic        w_is_h;
    logic        w_is_w;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_start_rmw;

    assign w_aligned = {addr[31:2], 2'b00};
    assign w_is_h    = (funct3 == F3_H) || (funct3 == F3_HU);
    assign w_is_w    = (funct3 == F3_W);

    assign w_misaligned = (w_is_h && addr[0]) || (w_is_w && (addr[1:0] != 2'b00));
    assign w_fault      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
                        || (req_we && funct3[2]) || (addr >= c_dmem_limit);

    lsu_align u_align (
        .i_funct3     (funct3),
        .i_offset     (addr[1:0]),
        .i_word       (mem_rdata),
        .i_wdata      (wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the merged word and target address when an RMW starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_merge <= RESET_VEC_DATA;
            r_addr  <= RESET_VEC_DATA;
        end else if (w_start_rmw) begin
            r_merge <= w_merge_word;
            r_addr  <= w_aligned;
        end
    end

    // Next-state and outputs; everything is held at zero while in reset
    always_comb begin
        w_next      = r_state;
        w_start_rmw = 1'b0;
        rdata       = 32'h0;
        stall       = 1'b0;
        misaligned  = 1'b0;
        fault       = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_misaligned) begin
                            misaligned = 1'b1;
                        end else if (w_fault) begin
                            fault = 1'b1;
                        end else if (!req_we) begin
                            mem_re   = 1'b1;
                            mem_addr = w_aligned;
                            rdata    = w_load_data;
                        end else if (w_is_w) begin
                            mem_we    = 1'b1;
                            mem_addr  = w_aligned;
                            mem_wdata = wdata;
                        end else begin
                            // Sub-word store: read now, write merged word next cycle
                            mem_re      = 1'b1;
                            mem_addr    = w_aligned;
                            stall       = 1'b1;
                            w_start_rmw = 1'b1;
                            w_next      = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    mem_we    = 1'b1;
                    mem_addr  = r_addr;
                    mem_wdata = r_merge;
                    w_next    = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Scoreboard testbench for lsu with a behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:511];

    typedef struct {
        string       name;
        logic        stall;
        logic        we;
        logic        re;
        logic        mis;
        logic        flt;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lsu #(.DMEM_BYTES(2048), .RESET_VEC_DATA(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .fault      (fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural dmem: combinational read, whole-word write on negedge
    assign mem_rdata = dmem[mem_addr[10:2]];
    always @(negedge clk) begin
        if (mem_we) dmem[mem_addr[10:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares the DUT outputs each cycle an expectation is queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall",      {31'h0, stall},      {31'h0, e.stall});
                chk(e.name, "mem_we",     {31'h0, mem_we},     {31'h0, e.we});
                chk(e.name, "mem_re",     {31'h0, mem_re},     {31'h0, e.re});
                chk(e.name, "misaligned", {31'h0, misaligned}, {31'h0, e.mis});
                chk(e.name, "fault",      {31'h0, fault},      {31'h0, e.flt});
                chk(e.name, "rdata",      rdata,               e.rdata);
                if (e.we || e.re) chk(e.name, "mem_addr", mem_addr, e.maddr);
                if (e.we)         chk(e.name, "mem_wdata", mem_wdata, e.wdata);
            end
        end
    end

    // One stimulus cycle: drive after the edge and queue the expected response
    task automatic step(input string nm, input logic rn, input logic v, input logic we,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic e_stall, input logic e_we, input logic e_re,
                        input logic e_mis, input logic e_flt, input logic [31:0] e_rdata,
                        input logic [31:0] e_maddr, input logic [31:0] e_wdata);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        req_valid = v;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        e.name  = nm;
        e.stall = e_stall;
        e.we    = e_we;
        e.re    = e_re;
        e.mis   = e_mis;
        e.flt   = e_flt;
        e.rdata = e_rdata;
        e.maddr = e_maddr;
        e.wdata = e_wdata;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 512; i++) dmem[i] = 32'h0;
        dmem[4]   = 32'hAABBCCDD;
        dmem[511] = 32'h12345678;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;

        //    name         rn v  we f3      addr      wdata         st we re mi fl rdata         maddr     wdata
        step("reset_gate", 0, 1, 0, 3'b010, 32'h10,  32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0);
        step("idle_nov",   1, 0, 0, 3'b010, 32'h10,  32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0);
        step("lb_11",      1, 1, 0, 3'b000, 32'h11,  32'h0,        0, 0, 1, 0, 0, 32'hFFFFFFCC, 32'h10, 32'h0);
        step("lbu_13",     1, 1, 0, 3'b100, 32'h13,  32'h0,        0, 0, 1, 0, 0, 32'h000000AA, 32'h10, 32'h0);
        step("lh_12",      1, 1, 0, 3'b001, 32'h12,  32'h0,        0, 0, 1, 0, 0, 32'hFFFFAABB, 32'h10, 32'h0);
        step("lhu_10",     1, 1, 0, 3'b101, 32'h10,  32'h0,        0, 0, 1, 0, 0, 32'h0000CCDD, 32'h10, 32'h0);
        step("lw_7fc",     1, 1, 0, 3'b010, 32'h7FC, 32'h0,        0, 0, 1, 0, 0, 32'h12345678, 32'h7FC, 32'h0);
        step("sb_12_rd",   1, 1, 1, 3'b000, 32'h12,  32'h12345655, 1, 0, 1, 0, 0, 32'h0,        32'h10, 32'h0);
        step("sb_12_wr",   1, 1, 1, 3'b000, 32'h12,  32'h12345655, 0, 1, 0, 0, 0, 32'h0,        32'h10, 32'hAA55CCDD);
        step("lw_after_sb",1, 1, 0, 3'b010, 32'h10,  32'h0,        0, 0, 1, 0, 0, 32'hAA55CCDD, 32'h10, 32'h0);
        step("sh_11_c1",   1, 1, 1, 3'b001, 32'h11,  32'hBEEF,     0, 0, 0, 1, 0, 32'h0,        32'h0,  32'h0);
        step("sh_11_c2",   1, 1, 1, 3'b001, 32'h11,  32'hBEEF,     0, 0, 0, 1, 0, 32'h0,        32'h0,  32'h0);
        step("lw_12_mis",  1, 1, 0, 3'b010, 32'h12,  32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0,  32'h0);
        step("lw_unchg",   1, 1, 0, 3'b010, 32'h10,  32'h0,        0, 0, 1, 0, 0, 32'hAA55CCDD, 32'h10, 32'h0);
        step("lw_800",     1, 1, 0, 3'b010, 32'h800, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,  32'h0);
        step("lh_801_pri", 1, 1, 0, 3'b001, 32'h801, 32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0,  32'h0);
        step("ld_f3_011",  1, 1, 0, 3'b011, 32'h10,  32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,  32'h0);
        step("sb_f3_100",  1, 1, 1, 3'b100, 32'h10,  32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,  32'h0);
        step("sw_restore", 1, 1, 1, 3'b010, 32'h10,  32'hAABBCCDD, 0, 1, 0, 0, 0, 32'h0,        32'h10, 32'hAABBCCDD);
        step("b2b_sb_rd",  1, 1, 1, 3'b000, 32'h10,  32'h11,       1, 0, 1, 0, 0, 32'h0,        32'h10, 32'h0);
        step("b2b_sb_wr",  1, 1, 1, 3'b000, 32'h10,  32'h11,       0, 1, 0, 0, 0, 32'h0,        32'h10, 32'hAABBCC11);
        step("b2b_sh_rd",  1, 1, 1, 3'b001, 32'h12,  32'h2233,     1, 0, 1, 0, 0, 32'h0,        32'h10, 32'h0);
        step("b2b_sh_wr",  1, 1, 1, 3'b001, 32'h12,  32'h2233,     0, 1, 0, 0, 0, 32'h0,        32'h10, 32'h2233CC11);
        step("lw_b2b",     1, 1, 0, 3'b010, 32'h10,  32'h0,        0, 0, 1, 0, 0, 32'h2233CC11, 32'h10, 32'h0);
        step("sw_restore2",1, 1, 1, 3'b010, 32'h10,  32'hAABBCCDD, 0, 1, 0, 0, 0, 32'h0,        32'h10, 32'hAABBCCDD);
        step("sb_13_rd",   1, 1, 1, 3'b000, 32'h13,  32'h99,       1, 0, 1, 0, 0, 32'h0,        32'h10, 32'h0);
        step("sb_13_rst",  0, 1, 1, 3'b000, 32'h13,  32'h99,       0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0);
        step("lw_post_rst",1, 1, 0, 3'b010, 32'h10,  32'h0,        0, 0, 1, 0, 0, 32'hAABBCCDD, 32'h10, 32'h0);
        step("idle_end",   1, 0, 0, 3'b000, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #5;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lsu
`default_nettype wire
